fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the pipelined CPU; supersedes the single-entry fetch stage.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 42 ++++
 rtl/fetch_queue_fifo.sv | 87 ++++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int unsigned DefPcWidth    = 17;
    localparam int unsigned DefInstrWidth = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [DefPcWidth-1:0]    pc;
        logic [DefInstrWidth-1:0] instr;
    } fetch_entry_t;

    // Fetch-to-decode handshake bundle at default widths.
    typedef struct packed {
        logic         valid;
        logic         ready;
        fetch_entry_t entry;
    } f2d_hs_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment: program-memory port,
// redirect input from execute and the fetch-to-decode handshake.
interface fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 17,
    parameter int unsigned INSTR_WIDTH = 32
) ();

    logic                   imem_req_out;
    logic [PC_WIDTH-1:0]    imem_addr_out;
    logic [INSTR_WIDTH-1:0] imem_instr_in;
    logic                   redirect_valid_in;
    logic [PC_WIDTH-1:0]    redirect_pc_in;
    logic                   f2d_valid_out;
    logic                   f2d_ready_in;
    logic [PC_WIDTH-1:0]    f2d_pc_out;
    logic [INSTR_WIDTH-1:0] f2d_instr_out;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_instr_in,
        input  redirect_valid_in,
        input  redirect_pc_in,
        output f2d_valid_out,
        input  f2d_ready_in,
        output f2d_pc_out,
        output f2d_instr_out
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_instr_in,
        output redirect_valid_in,
        output redirect_pc_in,
        input  f2d_valid_out,
        output f2d_ready_in,
        input  f2d_pc_out,
        input  f2d_instr_out
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous instruction FIFO with flush, occupancy count and a registered head
// entry so consumers never see a combinational path from pop to head.
module fetch_queue_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic                         head_valid_o,
    output entry_t                       head_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    entry_t                mem_q [Depth];
    entry_t                mem_d [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  head_valid_q, head_valid_d;
    entry_t                head_q, head_d;
    logic                  push_eff, pop_eff;

    // Next-state: pointer/count update, then look ahead to the next head entry.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_eff  = pop_i && (count_q != '0);
        // A push into a full queue is only legal when the head leaves the same cycle.
        push_eff = push_i && ((count_q != CntWidth'(Depth)) || pop_eff);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            end
            count_d = count_q + CntWidth'(push_eff) - CntWidth'(pop_eff);
        end
        head_valid_d = (count_d != '0);
        // The incoming entry becomes head when it lands exactly at the new read pointer.
        head_d = (push_eff && !flush_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i
                                                                   : mem_q[rd_ptr_d];
    end

    // Control and head registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // Storage array; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign count_o      = count_q;
    assign head_valid_o = head_valid_q;
    assign head_o       = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-based sequential fetch from a fixed-latency
// program memory, in-flight tracking, instruction FIFO and redirect flush.
// Optional build macro FETCH_PERF_EN adds fetched/flushed performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 17,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter int unsigned         MEM_LATENCY = 2,
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_out,
    output logic [31:0] perf_flushed_out
`endif
);

    localparam int unsigned CntWidth = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
    } pipe_t;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    pipe_t               pipe_q [MEM_LATENCY];
    pipe_t               pipe_d [MEM_LATENCY];

    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] issue_pc;
    logic                issue;
    logic [31:0]         inflight;
    logic                push, pop;
    entry_t              push_entry;
    logic [CntWidth-1:0] fifo_count;
    logic                head_valid;
    entry_t              head;
    logic                unused_redirect_lsb;

    // Issue decision: redirect always issues, otherwise only with a free credit.
    always_comb begin
        redirect            = bus.redirect_valid_in;
        target              = {bus.redirect_pc_in[PC_WIDTH-1:2], 2'b00};
        unused_redirect_lsb = ^bus.redirect_pc_in[1:0];
        inflight            = '0;
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            inflight = inflight + 32'(pipe_q[i].valid);
        end
        issue    = rst_in && (redirect || ((32'(fifo_count) + inflight) < QUEUE_DEPTH));
        issue_pc = redirect ? target : fetch_pc_q;
        fetch_pc_d = issue ? (issue_pc + PC_WIDTH'(4)) : fetch_pc_q;
        bus.imem_req_out  = issue;
        bus.imem_addr_out = issue_pc;
    end

    // In-flight shift register; a redirect kills everything older than its own request.
    always_comb begin
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_d[i] = '0;
        end
        pipe_d[0].valid = issue;
        pipe_d[0].pc    = issue_pc;
        for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipe_d[i]       = pipe_q[i-1];
            pipe_d[i].valid = pipe_q[i-1].valid && !redirect;
        end
    end

    // Response capture and decode handshake; both are void on a redirect cycle.
    always_comb begin
        push             = pipe_q[MEM_LATENCY-1].valid && !redirect;
        push_entry.pc    = pipe_q[MEM_LATENCY-1].pc;
        push_entry.instr = bus.imem_instr_in;
        pop              = bus.f2d_ready_in && head_valid && !redirect;
    end

    // Fetch PC and in-flight state registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pipe_q     <= pipe_d;
        end
    end

    fetch_queue_fifo #(
        .Depth   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk_i        (clk_in),
        .rst_ni       (rst_in),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect),
        .count_o      (fifo_count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    // Decode-facing outputs driven from the registered FIFO head.
    always_comb begin
        bus.f2d_valid_out = head_valid;
        bus.f2d_pc_out    = head_valid ? head.pc : '1;
        bus.f2d_instr_out = head_valid ? head.instr : INSTR_WIDTH'(NOP_INSTR);
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    // Counters: FIFO pushes and entries (queued or in flight) discarded by redirects.
    always_comb begin
        fetched_d = fetched_q + 32'(push);
        flushed_d = flushed_q;
        if (redirect) begin
            flushed_d = flushed_q + 32'(fifo_count) + inflight;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched_out = fetched_q;
    assign perf_flushed_out = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model answers requests after a
// fixed latency; a reference model predicts the sequential instruction stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned    PW  = 17;
    localparam int unsigned    IW  = 32;
    localparam int unsigned    ML  = 2;
    localparam int unsigned    QD  = 4;
    localparam logic [PW-1:0]  RPC = '0;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .MEM_LATENCY (ML),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (RPC)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_out (perf_fetched),
        .perf_flushed_out (perf_flushed)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Program-memory contents as a pure function of address.
    function automatic logic [31:0] mem_fn(input logic [PW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory model ----------------
    logic          s_req = 1'b0;
    logic [PW-1:0] s_addr = '0;
    logic          mv [ML];
    logic [PW-1:0] ma [ML];

    initial begin
        for (int i = 0; i < int'(ML); i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
        end
        bus.imem_instr_in = '0;
    end

    always @(posedge clk_in) begin
        #1;
        for (int i = int'(ML) - 1; i > 0; i--) begin
            mv[i] = mv[i-1];
            ma[i] = ma[i-1];
        end
        mv[0] = s_req;
        ma[0] = s_addr;
        bus.imem_instr_in = mv[ML-1] ? mem_fn(ma[ML-1]) : $urandom;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] exp_next;
    logic [PW-1:0] exp_req = RPC;
    int            hs_count = 0;
    int            req_count = 0;
    logic          rst_prev = 1'b0;

    // A new fetch stream starts at base: instructions arrive in PC order, +4 each.
    task automatic model_restart(input logic [PW-1:0] base);
        exp_q.delete();
        exp_next = base;
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + PW'(4);
        end
    endtask

    initial model_restart(RPC);

    // Monitor: values seen at negedge are those the DUT acts on at the next posedge.
    always @(negedge clk_in) begin
        logic [PW-1:0] tgt;
        logic [PW-1:0] pc_exp;
        s_req  = bus.imem_req_out;
        s_addr = bus.imem_addr_out;
        if (!rst_prev) begin
            check("rst_valid", 64'(bus.f2d_valid_out), 64'd0);
            check("rst_pc", 64'(bus.f2d_pc_out), 64'({PW{1'b1}}));
            check("rst_instr", 64'(bus.f2d_instr_out), 64'(NOP_INSTR));
        end
        if (!bus.f2d_valid_out) begin
            check("idle_instr", 64'(bus.f2d_instr_out), 64'(NOP_INSTR));
        end
        if (!rst_in) begin
            check("req_in_reset", 64'(bus.imem_req_out), 64'd0);
            model_restart(RPC);
            exp_req = RPC;
        end else if (bus.redirect_valid_in) begin
            tgt = {bus.redirect_pc_in[PW-1:2], 2'b00};
            check("redirect_req", 64'(bus.imem_req_out), 64'd1);
            check("redirect_addr", 64'(bus.imem_addr_out), 64'(tgt));
            exp_req = tgt + PW'(4);
            model_restart(tgt);
        end else begin
            if (bus.imem_req_out) begin
                check("req_addr", 64'(bus.imem_addr_out), 64'(exp_req));
                exp_req = exp_req + PW'(4);
                req_count++;
            end
            if (bus.f2d_valid_out && bus.f2d_ready_in) begin
                pc_exp = exp_q.pop_front();
                exp_q.push_back(exp_next);
                exp_next = exp_next + PW'(4);
                check("f2d_pc", 64'(bus.f2d_pc_out), 64'(pc_exp));
                check("f2d_instr", 64'(bus.f2d_instr_out), 64'(mem_fn(pc_exp)));
                hs_count++;
            end
        end
        rst_prev = rst_in;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_valid(input string name, input int exp_n);
        int n;
        n = 0;
        while (!bus.f2d_valid_out && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    task automatic redirect_to(input logic [PW-1:0] pc);
        bus.redirect_valid_in = 1'b1;
        bus.redirect_pc_in    = pc;
        tick();
        bus.redirect_valid_in = 1'b0;
    endtask

    initial begin
        int h0;
        int r0;
        bus.f2d_ready_in      = 1'b1;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = '0;
        rst_in                = 1'b0;
        repeat (3) tick();

        // First instruction three cycles after the first request, then one per cycle.
        rst_in = 1'b1;
        wait_valid("first_valid_latency", 3);
        h0 = hs_count;
        repeat (20) tick();
        check("throughput", 64'(hs_count - h0), 64'd20);

        // Stalled decode: credits stop issue at four outstanding.
        rst_in = 1'b0;
        bus.f2d_ready_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        r0 = req_count;
        repeat (10) tick();
        check("req_count_full", 64'(req_count - r0), 64'(QD));
        check("req_when_full", 64'(bus.imem_req_out), 64'd0);
        check("valid_when_full", 64'(bus.f2d_valid_out), 64'd1);
        bus.f2d_ready_in = 1'b1;
        h0 = hs_count;
        repeat (12) tick();
        check("drain_count", 64'(hs_count - h0), 64'd12);

        // Redirect with work queued and in flight.
        bus.f2d_ready_in = 1'b0;
        repeat (4) tick();
        bus.f2d_ready_in = 1'b1;
        redirect_to(PW'(17'h104));
        check("flushed_valid", 64'(bus.f2d_valid_out), 64'd0);
        wait_valid("redirect_latency", 2);
        repeat (6) tick();

        // Back-to-back redirects: only the second survives.
        bus.redirect_valid_in = 1'b1;
        bus.redirect_pc_in    = PW'(17'h40);
        tick();
        redirect_to(PW'(17'h80));
        wait_valid("double_redirect_latency", 2);
        repeat (6) tick();

        // Address wrap and unaligned redirect target.
        redirect_to(PW'(17'h1FFF8));
        repeat (10) tick();
        redirect_to(PW'(17'h0107));
        repeat (6) tick();

        // Reset with requests in flight.
        redirect_to(PW'(17'h200));
        tick();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
`ifdef FETCH_PERF_EN
        check("perf_fetched_rst", 64'(perf_fetched), 64'd0);
        check("perf_flushed_rst", 64'(perf_flushed), 64'd0);
`endif
        wait_valid("post_reset_latency", 3);

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            bus.f2d_ready_in      = ($urandom_range(0, 99) < 70);
            bus.redirect_valid_in = ($urandom_range(0, 99) < 6);
            bus.redirect_pc_in    = PW'($urandom);
            rst_in                = ($urandom_range(0, 99) >= 1);
            tick();
        end
        bus.redirect_valid_in = 1'b0;
        bus.f2d_ready_in      = 1'b1;
        rst_in                = 1'b1;
        h0 = hs_count;
        repeat (20) tick();
        check("final_progress", 64'(hs_count - h0 >= 15), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
